// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: multi-cycle sequencer for brzr/brnz/brpl/brmi on the bus-based CPU.
// Optional macro BRANCH_STATS_EN adds saturating taken / not-taken outcome counters.
module branch_seq_ctrl #(
    parameter int unsigned DATA_W    = 32,
`ifdef BRANCH_STATS_EN
    parameter int unsigned CNT_W     = 16,
`endif
    parameter logic [4:0]  BR_OPCODE = 5'b10010
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] IRIn,
    input  logic              con_q,
    output logic              busy,
    output logic              done,
    output logic              taken,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt,
`endif
    output logic              illegal,
    output logic              ra_out,
    output logic              con_in,
    output logic              pc_out,
    output logic              y_in,
    output logic              c_sign_out,
    output logic              alu_add,
    output logic              z_in,
    output logic              zlo_out,
    output logic              pc_in
);

    localparam int unsigned OPC_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EVAL  = 3'd1,
        ST_CHECK = 3'd2,
        ST_PC_Y  = 3'd3,
        ST_ADD   = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic ra_out;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_sign_out;
        logic alu_add;
        logic z_in;
        logic zlo_out;
        logic pc_in;
        logic done;
    } strobe_t;

    state_t             r_state;
    state_t             w_state_nxt;
    strobe_t            r_strb;
    strobe_t            w_strb_nxt;
    logic               r_busy;
    logic               r_illegal;
    logic               r_taken;
    logic               w_illegal_nxt;
    logic               w_taken_nxt;
    logic [OPC_W-1:0]   w_opcode;
    logic               w_br_hit;
    logic               w_unused_ir;

    assign w_opcode    = IRIn[DATA_W-1 -: OPC_W];
    assign w_br_hit    = (w_opcode == BR_OPCODE);
    assign w_unused_ir = ^IRIn[DATA_W-OPC_W-1:0];

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, outcome update, and strobes decoded from the upcoming state
    always_comb begin
        w_state_nxt   = r_state;
        w_illegal_nxt = 1'b0;
        w_taken_nxt   = r_taken;
        w_strb_nxt    = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_br_hit) begin
                        w_state_nxt = ST_EVAL;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end
            end
            ST_EVAL:  w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (con_q) begin
                    w_state_nxt = ST_PC_Y;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_taken_nxt = 1'b0;
                end
            end
            ST_PC_Y:  w_state_nxt = ST_ADD;
            ST_ADD:   w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                w_state_nxt = ST_DONE;
                w_taken_nxt = 1'b1;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_EVAL: begin
                w_strb_nxt.ra_out = 1'b1;
                w_strb_nxt.con_in = 1'b1;
            end
            ST_PC_Y: begin
                w_strb_nxt.pc_out = 1'b1;
                w_strb_nxt.y_in   = 1'b1;
            end
            ST_ADD: begin
                w_strb_nxt.c_sign_out = 1'b1;
                w_strb_nxt.alu_add    = 1'b1;
                w_strb_nxt.z_in       = 1'b1;
            end
            ST_WRITE: begin
                w_strb_nxt.zlo_out = 1'b1;
                w_strb_nxt.pc_in   = 1'b1;
            end
            ST_DONE:  w_strb_nxt.done = 1'b1;
            default:  w_strb_nxt = '0;
        endcase
    end

    // Output registers track the state register so reset clears them in the same cycle
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_strb    <= '0;
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
            r_taken   <= 1'b0;
        end else begin
            r_strb    <= w_strb_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_illegal <= w_illegal_nxt;
            r_taken   <= w_taken_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_strb.done;
    assign taken      = r_taken;
    assign illegal    = r_illegal;
    assign ra_out     = r_strb.ra_out;
    assign con_in     = r_strb.con_in;
    assign pc_out     = r_strb.pc_out;
    assign y_in       = r_strb.y_in;
    assign c_sign_out = r_strb.c_sign_out;
    assign alu_add    = r_strb.alu_add;
    assign z_in       = r_strb.z_in;
    assign zlo_out    = r_strb.zlo_out;
    assign pc_in      = r_strb.pc_in;

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_not_taken_cnt;

    // Outcome counters: bump once per completed branch, stick at all-ones
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_taken_cnt     <= '0;
            r_not_taken_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            if (r_taken) begin
                if (r_taken_cnt != CNT_MAX) begin
                    r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                end
            end else begin
                if (r_not_taken_cnt != CNT_MAX) begin
                    r_not_taken_cnt <= r_not_taken_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign taken_cnt     = r_taken_cnt;
    assign not_taken_cnt = r_not_taken_cnt;
`endif

    // Bus contention and handshake sanity
    a_one_bus_driver: assert property (@(posedge clock) disable iff (!clear)
        $onehot0({ra_out, pc_out, c_sign_out, zlo_out}));

    a_done_while_busy: assert property (@(posedge clock) disable iff (!clear)
        done |-> busy);

    a_no_illegal_while_busy: assert property (@(posedge clock) disable iff (!clear)
        illegal |-> !busy);

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// tb_branch_seq_ctrl: scoreboard bench for branch_seq_ctrl; expected strobe traces and
// completion events are queued at issue time and popped by an independent monitor.
module tb_branch_seq_ctrl;

    localparam logic [31:0] IR_BRZR_R1 = 32'h9080_0014;
    localparam logic [31:0] IR_BRMI_R5 = 32'h92BF_FFF0;
    localparam logic [31:0] IR_ILLEGAL = 32'h1800_0000;

    // {ra_out,con_in,pc_out,y_in,c_sign_out,alu_add,z_in,zlo_out,pc_in,done}
    localparam logic [9:0] S_EVAL  = 10'b11_0000_0000;
    localparam logic [9:0] S_CHECK = 10'b00_0000_0000;
    localparam logic [9:0] S_PCY   = 10'b00_1100_0000;
    localparam logic [9:0] S_ADD   = 10'b00_0011_1000;
    localparam logic [9:0] S_WRITE = 10'b00_0000_0110;
    localparam logic [9:0] S_DONE  = 10'b00_0000_0001;

    typedef struct {
        bit is_illegal;
        bit exp_taken;
        int exp_cyc;
    } ev_t;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] IRIn  = '0;
    logic        con_q = 1'b0;
    logic        busy, done, taken, illegal;
    logic        ra_out, con_in, pc_out, y_in, c_sign_out, alu_add, z_in, zlo_out, pc_in;
`ifdef BRANCH_STATS_EN
    logic [1:0]  taken_cnt, not_taken_cnt;
`endif

    int   cyc     = 0;
    int   chk_cyc = -1;
    bit   chk_val = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;
    ev_t  ev_q[$];
    logic [9:0] strb_q[$];

    branch_seq_ctrl #(
        .DATA_W    (32),
`ifdef BRANCH_STATS_EN
        .CNT_W     (2),
`endif
        .BR_OPCODE (5'b10010)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .start         (start),
        .IRIn          (IRIn),
        .con_q         (con_q),
        .busy          (busy),
        .done          (done),
        .taken         (taken),
`ifdef BRANCH_STATS_EN
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt),
`endif
        .illegal       (illegal),
        .ra_out        (ra_out),
        .con_in        (con_in),
        .pc_out        (pc_out),
        .y_in          (y_in),
        .c_sign_out    (c_sign_out),
        .alu_add       (alu_add),
        .z_in          (z_in),
        .zlo_out       (zlo_out),
        .pc_in         (pc_in)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [9:0] strobes();
        return {ra_out, con_in, pc_out, y_in, c_sign_out, alu_add, z_in, zlo_out, pc_in, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CON result is presented only in the CHECK cycle; the inverse elsewhere must be ignored
    initial forever begin
        @(negedge clock);
        con_q = (cyc == chk_cyc) ? chk_val : ~chk_val;
    end

    // Monitor: pop expected strobes while busy, expected events on done/illegal
    initial forever begin
        ev_t        e;
        logic [9:0] exp_s;
        @(negedge clock);
        #1;
        if (clear) begin
            if (busy) begin
                if (strb_q.size() == 0) begin
                    check("unexpected_busy_strobes", {22'd0, strobes()}, 32'hFFFF_FFFF);
                end else begin
                    exp_s = strb_q.pop_front();
                    check("strobes", {22'd0, strobes()}, {22'd0, exp_s});
                end
            end
            if (done || illegal) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_event", {30'd0, done, illegal}, 32'd0);
                end else begin
                    e = ev_q.pop_front();
                    check("event_kind_illegal", {31'd0, illegal}, {31'd0, e.is_illegal});
                    check("event_cycle", cyc, e.exp_cyc);
                    if (!e.is_illegal) check("taken_at_done", {31'd0, taken}, {31'd0, e.exp_taken});
                end
            end
        end
    end

    // Called at a negedge; drives a one-cycle start and queues the hand-derived response
    task automatic issue(input logic [31:0] ir, input bit con, input bit exp_ill,
                         input bit exp_tk, input int lat);
        ev_t e;
        IRIn    = ir;
        start   = 1'b1;
        chk_cyc = cyc + 2;
        chk_val = con;
        e.is_illegal = exp_ill;
        e.exp_taken  = exp_tk;
        e.exp_cyc    = cyc + lat;
        ev_q.push_back(e);
        if (!exp_ill) begin
            strb_q.push_back(S_EVAL);
            strb_q.push_back(S_CHECK);
            if (exp_tk) begin
                strb_q.push_back(S_PCY);
                strb_q.push_back(S_ADD);
                strb_q.push_back(S_WRITE);
            end
            strb_q.push_back(S_DONE);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] ir);
        IRIn  = ir;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait (bounded) for all expectations to be consumed, then one idle cycle
    task automatic drain();
        int i;
        i = 0;
        while ((ev_q.size() != 0 || strb_q.size() != 0) && i < 64) begin
            @(negedge clock);
            i++;
        end
        check("drain_pending", ev_q.size() + strb_q.size(), 0);
        ev_q.delete();
        strb_q.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        clear = 1'b0;
        #1;
        ev_q.delete();
        strb_q.delete();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

    initial begin
        int c;
        // Reset from power-up
        #2 clear = 1'b0;
        #1;
        check("reset_outputs", {19'd0, busy, illegal, taken, strobes()}, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("idle_busy_after_reset", {31'd0, busy}, 32'd0);

        // Taken brzr: DONE at k+6, taken latched
        issue(IR_BRZR_R1, 1'b1, 1'b0, 1'b1, 6);
        drain();
        check("taken_held", {31'd0, taken}, 32'd1);

        // Not taken: DONE at k+3, taken cleared
        issue(IR_BRZR_R1, 1'b0, 1'b0, 1'b0, 3);
        drain();
        check("not_taken_held", {31'd0, taken}, 32'd0);

        // Taken with another opcode encoding in the same class, then illegal leaves taken alone
        issue(IR_BRMI_R5, 1'b1, 1'b0, 1'b1, 6);
        drain();
        issue(IR_ILLEGAL, 1'b0, 1'b1, 1'b0, 1);
        check("illegal_not_busy", {31'd0, busy}, 32'd0);
        drain();
        check("taken_after_illegal", {31'd0, taken}, 32'd1);

        // Collisions: start at k+2 and in DONE ignored; start after done accepted
        c = cyc;
        issue(IR_BRZR_R1, 1'b1, 1'b0, 1'b1, 6);
        @(negedge clock);
        check("collide_at", cyc, c + 2);
        pulse_start(IR_BRZR_R1);
        repeat (3) @(negedge clock);
        check("done_cycle_for_collision", {31'd0, done}, 32'd1);
        pulse_start(IR_BRZR_R1);
        issue(IR_BRZR_R1, 1'b0, 1'b0, 1'b0, 3);
        check("accept_after_done_busy", {31'd0, busy}, 32'd1);
        drain();

        // Reset during ADD: everything drops at once, PC never loaded
        issue(IR_BRZR_R1, 1'b1, 1'b0, 1'b1, 6);
        repeat (3) @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("midrun_reset_outputs", {19'd0, busy, illegal, taken, strobes()}, 32'd0);
        ev_q.delete();
        strb_q.delete();
        @(negedge clock);
        check("pc_in_in_reset", {31'd0, pc_in}, 32'd0);
        clear = 1'b1;
        @(negedge clock);
        check("pc_in_after_reset", {31'd0, pc_in}, 32'd0);
        check("busy_after_midrun_reset", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("pc_in_idle", {31'd0, pc_in}, 32'd0);

`ifdef BRANCH_STATS_EN
        do_reset();
        check("stats_reset_taken", {30'd0, taken_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            issue(IR_BRZR_R1, 1'b1, 1'b0, 1'b1, 6);
            drain();
        end
        for (int i = 0; i < 2; i++) begin
            issue(IR_BRZR_R1, 1'b0, 1'b0, 1'b0, 3);
            drain();
        end
        issue(IR_ILLEGAL, 1'b0, 1'b1, 1'b0, 1);
        drain();
        check("taken_cnt_saturated", {30'd0, taken_cnt}, 32'd3);
        check("not_taken_cnt", {30'd0, not_taken_cnt}, 32'd2);
        do_reset();
        check("taken_cnt_cleared", {30'd0, taken_cnt}, 32'd0);
        check("not_taken_cnt_cleared", {30'd0, not_taken_cnt}, 32'd0);
`else
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
